serial_sub: RTL and testbench

Bit-serial N-bit subtractor built around the team's single-bit full-subtractor cell plus a borrow flip-flop. It computes a - b - bin over WIDTH cycles, LSB first. Sits directly upstream of consumers of the one-bit cell's outputs, and replaces a WIDTH-cell ripple chain where area matters more than latency. Handshake is start/busy/done.

---
 rtl/serial_sub_pkg.sv | 18 +
 rtl/serial_sub_full_sub.sv | 13 +
 rtl/serial_sub.sv | 94 +++++++++
 tb/tb_serial_sub.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// a constant-evaluable clog2 used to size the bit counter.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/serial_sub_full_sub.sv
// Single-bit full-subtractor cell: d = a - b - bin, bout set on underflow.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor (a - b - bin), LSB first, one full_sub
// cell plus a borrow flip-flop; start/busy/done handshake.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CW = clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             d;
    logic             bo;

    full_sub u_cell (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (br),
        .d    (d),
        .bout (bo)
    );

    // Concatenate-then-shift so the same expression also covers WIDTH=1.
    assign sr_next = WIDTH'({d, sr} >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sr  <= sr_next;
                    br  <= bo;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff  <= sr_next;
                        bout  <= bo;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: scoreboard of expected results checked
// on every done pulse, plus directed timing/handshake/reset checks.
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, bin;
    logic [7:0] a, b, diff;
    logic       busy, done, bout;

    logic       start1, bin1;
    logic [0:0] a1, b1, diff1;
    logic       busy1, done1, bout1;

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;
    int n_exp_done = 0;
    logic [8:0] q[$];
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
    );

    serial_sub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
    );

    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic bi);
        return {1'b0, x} - {1'b0, y} - {8'd0, bi};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [7:0] x, input logic [7:0] y, input logic bi);
        int t;
        t = 0;
        while (busy && t < 50) begin
            step();
            t++;
        end
        check("accept_wait", {31'd0, busy}, 32'd0);
        a = x; b = y; bin = bi; start = 1'b1;
        q.push_back(model(x, y, bi));
        n_exp_done++;
        step();
        start = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 200) begin
            step();
            t++;
        end
        check("drain", q.size(), 32'd0);
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            check("done_single_cycle", {31'd0, prev_done}, 32'd0);
            check("done_expected", {31'd0, q.size() != 0}, 32'd1);
            if (q.size() != 0) check("result", {23'd0, bout, diff}, {23'd0, q.pop_front()});
        end
        prev_done = done;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [7:0] ta[4];
        logic [7:0] tb[4];
        logic       tc[4];
        logic [0:0] wa[3];
        logic [0:0] wb[3];
        logic       wc[3];
        logic [1:0] we[3];
        logic [8:0] e;

        ta = '{8'd10, 8'd3, 8'd128, 8'd77};
        tb = '{8'd3, 8'd10, 8'd1, 8'd77};
        tc = '{1'b0, 1'b1, 1'b1, 1'b1};
        wa = '{1'b0, 1'b1, 1'b1};
        wb = '{1'b1, 1'b0, 1'b0};
        wc = '{1'b0, 1'b1, 1'b0};
        we = '{2'b11, 2'b00, 2'b01};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {24'd0, diff}, 32'd0);
        check("rst_bout", {31'd0, bout}, 32'd0);
        rst = 1'b0;
        step();

        // 100 - 37: busy for 8 cycles, done on the 9th
        op(8'd100, 8'd37, 1'b0);
        for (int i = 1; i < 8; i++) begin
            step();
            check("t1_busy", {31'd0, busy}, 32'd1);
            check("t1_no_done", {31'd0, done}, 32'd0);
        end
        step();
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_busy_low", {31'd0, busy}, 32'd0);
        check("t1_diff", {24'd0, diff}, 32'd63);
        check("t1_bout", {31'd0, bout}, 32'd0);

        op(8'd5, 8'd9, 1'b0);
        op(8'd0, 8'd0, 1'b1);
        op(8'd255, 8'd255, 1'b0);
        drain();

        // start re-pulse during SHIFT is ignored
        op(8'd200, 8'd17, 1'b1);
        step(); step();
        a = 8'd1; b = 8'd1; bin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        drain();
        repeat (12) step();
        check("t3_done_count", n_done, n_exp_done);

        // start held high: a new request accepted in every DONE cycle
        a = ta[0]; b = tb[0]; bin = tc[0]; start = 1'b1;
        q.push_back(model(ta[0], tb[0], tc[0]));
        n_exp_done++;
        step();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 7; j++) begin
                check("t4_busy", {31'd0, busy}, 32'd1);
                a = 8'($urandom); b = 8'($urandom);
                step();
            end
            check("t4_busy_last", {31'd0, busy}, 32'd1);
            step();
            check("t4_done", {31'd0, done}, 32'd1);
            check("t4_busy_low", {31'd0, busy}, 32'd0);
            if (i < 3) begin
                a = ta[i+1]; b = tb[i+1]; bin = tc[i+1];
                q.push_back(model(ta[i+1], tb[i+1], tc[i+1]));
                n_exp_done++;
            end else begin
                start = 1'b0;
            end
            step();
        end
        drain();
        check("t4_hold_diff", {24'd0, diff}, 32'd255);

        // asynchronous reset mid-SHIFT
        op(8'd50, 8'd20, 1'b0);
        step(); step(); step();
        #2 rst = 1'b1;
        #1;
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_done", {31'd0, done}, 32'd0);
        check("t5_diff", {24'd0, diff}, 32'd0);
        check("t5_bout", {31'd0, bout}, 32'd0);
        void'(q.pop_back());
        n_exp_done--;
        #3 rst = 1'b0;
        step();
        repeat (10) step();
        check("t5_no_done", n_done, n_exp_done);
        op(8'd50, 8'd20, 1'b0);
        drain();

        // WIDTH=1 instance
        for (int i = 0; i < 3; i++) begin
            a1 = wa[i]; b1 = wb[i]; bin1 = wc[i]; start1 = 1'b1;
            step();
            start1 = 1'b0;
            check("w1_busy", {31'd0, busy1}, 32'd1);
            check("w1_no_done", {31'd0, done1}, 32'd0);
            step();
            check("w1_done", {31'd0, done1}, 32'd1);
            check("w1_busy_low", {31'd0, busy1}, 32'd0);
            check("w1_result", {30'd0, bout1, diff1}, {30'd0, we[i]});
            step();
        end

        // randomised operations
        repeat (1000) begin
            e = 9'($urandom);
            op(8'($urandom), e[7:0], 1'($urandom_range(0, 1)));
        end
        drain();
        repeat (3) step();
        check("final_done_count", n_done, n_exp_done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
